hash_engine_arbiter: RTL and testbench

Shares one hash_compression SHA-256 engine between NUM_REQ requesters.
- Grants are round-robin at message granularity: the winner owns the engine from its first block through its data_in_last block and the return of its digest.
- The registered digest is returned on a shared response bus tagged with the owner's ID.
- Sits between the requester-facing wrappers and the engine's data_in/data_out handshake ports.

---
 rtl/hash_arb_pkg.sv | 14 +
 rtl/rr_grant.sv | 50 +++++
 rtl/hash_engine_arbiter.sv | 153 +++++++++++++++
 tb/tb_hash_engine_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_arb_pkg.sv
// Shared types and widths for the hash engine arbiter.
package hash_arb_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational grant picker for the hash engine arbiter.
// Default: round-robin scan starting at i_ptr with wraparound.
// HASH_ARB_FIXED_PRIO_EN: lowest-index valid requester wins, i_ptr ignored.
module rr_grant #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned REQ_ID_W = 2
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [REQ_ID_W-1:0] i_ptr,
  output logic [REQ_ID_W-1:0] o_idx,
  output logic                o_any
);

`ifdef HASH_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = REQ_ID_W'(i);
        o_any = 1'b1;
      end
    end
  end
`else
  int                  w_sum;
  logic [REQ_ID_W-1:0] w_idx;

  // Walk offsets from far to near so the smallest offset from i_ptr wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_sum = 0;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = int'(i_ptr) + i;
      w_idx = REQ_ID_W'(w_sum % NUM_REQ);
      if (i_req[w_idx]) begin
        o_idx = w_idx;
        o_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/hash_engine_arbiter.sv
// Shares one SHA-256 compression engine between NUM_REQ requesters. A winner
// keeps the engine from its first block until its digest is taken from the
// response bus. Optional macro HASH_ARB_FIXED_PRIO_EN swaps round-robin
// arbitration for fixed lowest-index priority (rr_ptr then reads as 0).
module hash_engine_arbiter
  import hash_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned REQ_ID_W = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [BLOCK_W-1:0]         eng_data_in,
  output logic                       eng_data_in_last,
  output logic                       eng_data_in_valid,
  input  logic                       eng_data_in_ready,
  input  logic [DIGEST_W-1:0]        eng_data_out,
  input  logic                       eng_data_out_last,
  input  logic                       eng_data_out_valid,
  output logic                       eng_data_out_ready,
  output logic [DIGEST_W-1:0]        rsp_data,
  output logic [REQ_ID_W-1:0]        rsp_id,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       busy
);

  arb_state_t          r_state;
  logic [REQ_ID_W-1:0] r_owner;
  logic [DIGEST_W-1:0] r_rsp_data;
  logic [REQ_ID_W-1:0] r_rsp_id;
  logic                r_rsp_valid;

  logic [REQ_ID_W-1:0] w_rr_ptr;
  logic [REQ_ID_W-1:0] w_grant;
  logic                w_any;
  logic [BLOCK_W-1:0]  w_owner_data;
  logic                w_owner_last;
  logic                w_owner_valid;
  logic                w_in_hs;
  logic                w_unused_last;

  // The engine always flags its single digest beat as last.
  assign w_unused_last = eng_data_out_last;

  rr_grant #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_rr_grant (
    .i_req (req_valid),
    .i_ptr (w_rr_ptr),
    .o_idx (w_grant),
    .o_any (w_any)
  );

  // Select the owner's block, last flag and valid.
  always_comb begin
    w_owner_data  = '0;
    w_owner_last  = 1'b0;
    w_owner_valid = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_owner == REQ_ID_W'(r)) begin
        w_owner_data  = req_data[r*BLOCK_W +: BLOCK_W];
        w_owner_last  = req_last[r];
        w_owner_valid = req_valid[r];
      end
    end
  end

  // Pass-through to the engine; only the owner ever sees ready.
  always_comb begin
    eng_data_in       = w_owner_data;
    eng_data_in_last  = (r_state == FWD) && w_owner_last;
    eng_data_in_valid = (r_state == FWD) && w_owner_valid;
    req_ready         = '0;
    if (r_state == FWD) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        req_ready[r] = (r_owner == REQ_ID_W'(r)) && eng_data_in_ready;
      end
    end
  end

  assign w_in_hs            = eng_data_in_valid && eng_data_in_ready;
  assign eng_data_out_ready = (r_state == WAIT);
  assign busy               = (r_state != IDLE);
  assign rsp_data           = r_rsp_data;
  assign rsp_id             = r_rsp_id;
  assign rsp_valid          = r_rsp_valid;

  // Message-granular lock: arbitrate, forward blocks, collect digest, respond.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_state <= FWD;
          end
        end
        FWD: begin
          if (w_in_hs && w_owner_last) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (eng_data_out_valid) begin
            r_rsp_data  <= eng_data_out;
            r_rsp_id    <= r_owner;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HASH_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [REQ_ID_W-1:0] r_rr_ptr;
  logic [REQ_ID_W-1:0] w_next_ptr;

  assign w_next_ptr = (r_owner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_rr_ptr   = r_rr_ptr;

  // Advance the scan start past the owner once its response is taken.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_rr_ptr <= '0;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`endif

endmodule

// File: tb/tb_hash_engine_arbiter.sv
// Directed bench for hash_engine_arbiter with a behavioural SHA-256 engine.
module tb_hash_engine_arbiter;

  localparam int NR = 4;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_448 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC  = {24'h616263, 8'h80, 416'h0, 64'h18};
  localparam logic [447:0] MSG448   =
    "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
  localparam logic [511:0] BLK_448A = {MSG448, 8'h80, 56'h0};
  localparam logic [511:0] BLK_448B = {448'h0, 64'd448};
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

`ifdef HASH_ARB_FIXED_PRIO_EN
  localparam int PRIO_ORDER [6] = '{0, 0, 0, 3, 3, 3};
  localparam logic [1:0] PTR_AFTER_ABC = 2'd0;
  localparam logic [1:0] PTR_AFTER_TWO = 2'd0;
`else
  localparam int PRIO_ORDER [6] = '{0, 3, 0, 3, 0, 3};
  localparam logic [1:0] PTR_AFTER_ABC = 2'd1;
  localparam logic [1:0] PTR_AFTER_TWO = 2'd3;
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic              clk = 1'b0;
  logic              nrst;
  logic [NR*512-1:0] req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [511:0]      eng_data_in;
  logic              eng_data_in_last;
  logic              eng_data_in_valid;
  logic              eng_data_in_ready;
  logic [255:0]      eng_data_out;
  logic              eng_data_out_last;
  logic              eng_data_out_valid;
  logic              eng_data_out_ready;
  logic [255:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hash_engine_arbiter #(
    .NUM_REQ  (NR),
    .REQ_ID_W (2)
  ) dut (
    .clk                (clk),
    .nrst               (nrst),
    .req_data           (req_data),
    .req_last           (req_last),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .eng_data_in        (eng_data_in),
    .eng_data_in_last   (eng_data_in_last),
    .eng_data_in_valid  (eng_data_in_valid),
    .eng_data_in_ready  (eng_data_in_ready),
    .eng_data_out       (eng_data_out),
    .eng_data_out_last  (eng_data_out_last),
    .eng_data_out_valid (eng_data_out_valid),
    .eng_data_out_ready (eng_data_out_ready),
    .rsp_data           (rsp_data),
    .rsp_id             (rsp_id),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .busy               (busy)
  );

  // ---------------- behavioural SHA-256 engine ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin,
                                                input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) hout[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
    return hout;
  endfunction

  logic [255:0] e_h;
  logic         e_first;
  logic         e_pend_last;
  int           e_cnt;

  assign eng_data_in_ready = nrst && (e_cnt == 0) && !eng_data_out_valid;
  assign eng_data_out      = e_h;
  assign eng_data_out_last = 1'b1;

  always @(posedge clk) begin
    if (!nrst) begin
      e_h                <= '0;
      e_first            <= 1'b1;
      e_pend_last        <= 1'b0;
      e_cnt              <= 0;
      eng_data_out_valid <= 1'b0;
    end else if (eng_data_out_valid) begin
      if (eng_data_out_ready) begin
        eng_data_out_valid <= 1'b0;
        e_first            <= 1'b1;
        e_pend_last        <= 1'b0;
      end
    end else if (e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
      if (e_cnt == 1 && e_pend_last) eng_data_out_valid <= 1'b1;
    end else if (eng_data_in_valid && eng_data_in_ready) begin
      e_h         <= sha_compress(e_first ? IV : e_h, eng_data_in);
      e_first     <= 1'b0;
      e_cnt       <= 4;
      e_pend_last <= eng_data_in_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [511:0] m_blk   [NR][8];
  logic         m_last  [NR][8];
  int           m_n     [NR];
  int           m_start [NR];

  int           g_ids   [$];
  logic [255:0] g_digs  [$];
  int           g_order [$];
  int           bad_watch;
  int           multi_ready;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic clear_msgs();
    for (int r = 0; r < NR; r++) begin
      m_n[r]     = 0;
      m_start[r] = 0;
    end
  endtask

  task automatic add_blk(input int r, input logic [511:0] blk, input logic last);
    m_blk[r][m_n[r]]  = blk;
    m_last[r][m_n[r]] = last;
    m_n[r]++;
  endtask

  // Drives every requester's block list, accepts responses immediately.
  task automatic run(input int exp_resp, input int watch, input int budget);
    int pos [NR];
    logic [NR-1:0] hs;
    for (int r = 0; r < NR; r++) pos[r] = 0;
    g_ids.delete();
    g_digs.delete();
    g_order.delete();
    bad_watch   = 0;
    multi_ready = 0;
    rsp_ready   = 1'b1;
    for (int cyc = 0; cyc < budget && g_ids.size() < exp_resp; cyc++) begin
      for (int r = 0; r < NR; r++) begin
        if (pos[r] < m_n[r] && cyc >= m_start[r]) begin
          req_valid[r]            = 1'b1;
          req_last[r]             = m_last[r][pos[r]];
          req_data[512*r +: 512]  = m_blk[r][pos[r]];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
      #1;
      hs = req_ready & req_valid;
      if ($countones(req_ready) > 1) multi_ready++;
      if (watch >= 0 && req_ready[watch] && g_ids.size() == 0) bad_watch++;
      if (rsp_valid) begin
        g_ids.push_back(int'(rsp_id));
        g_digs.push_back(rsp_data);
      end
      tick();
      for (int r = 0; r < NR; r++) begin
        if (hs[r]) begin
          if (pos[r] == 0 || m_last[r][pos[r]-1]) g_order.push_back(r);
          pos[r]++;
        end
      end
    end
    req_valid = '0;
    req_last  = '0;
    rsp_ready = 1'b0;
    n_checks++;
    if (g_ids.size() != exp_resp) begin
      n_fail++;
      $display("FAIL run_resp_count: got %0d expected %0d", g_ids.size(), exp_resp);
    end
  endtask

  task automatic wait_hs(input int r, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      if (req_ready[r]) ok = 1'b1;
      tick();
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_hs_timeout: requester %0d got no ready in %0d cycles", r, budget);
    end
  endtask

  task automatic wait_rsp(input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_rsp_timeout: got rsp_valid=0 expected 1 within %0d cycles", budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nrst      = 1'b0;
    rsp_ready = 1'b0;
    req_data  = '0;
    req_last  = '0;
    req_valid = 4'hF;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_data !== 256'h0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if (rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    n_checks++; if (req_ready !== 4'h0) begin
      n_fail++; $display("FAIL reset_req_ready: got %h expected 0", req_ready); end
    n_checks++; if (eng_data_in_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_eng_in_valid: got %b expected 0", eng_data_in_valid); end
    n_checks++; if (eng_data_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_eng_out_ready: got %b expected 0", eng_data_out_ready); end
    n_checks++; if (dut.w_rr_ptr !== 2'd0) begin
      n_fail++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.w_rr_ptr); end
    n_checks++; if (dut.r_owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_owner: got %0d expected 0", dut.r_owner); end
    req_valid = '0;
    nrst      = 1'b1;
  endtask

  task automatic test_abc();
    clear_msgs();
    add_blk(0, BLK_ABC, 1'b1);
    run(1, -1, 100);
    n_checks++; if (g_ids.size() < 1 || g_ids[0] != 0) begin
      n_fail++; $display("FAIL abc_id: got %0d expected 0", g_ids.size() ? g_ids[0] : -1); end
    n_checks++; if (g_digs.size() < 1 || g_digs[0] !== DIG_ABC) begin
      n_fail++; $display("FAIL abc_digest: got %h expected %h", g_digs[0], DIG_ABC); end
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL abc_idle_after: got busy=%b rsp_valid=%b expected 0 0",
                         busy, rsp_valid); end
    n_checks++; if (dut.w_rr_ptr !== PTR_AFTER_ABC) begin
      n_fail++; $display("FAIL abc_rr_ptr: got %0d expected %0d", dut.w_rr_ptr, PTR_AFTER_ABC);
    end
  endtask

  task automatic test_two_req();
    do_reset();
    clear_msgs();
    add_blk(1, BLK_ABC, 1'b1);
    add_blk(2, BLK_ABC, 1'b1);
    run(2, -1, 200);
    n_checks++; if (g_order.size() != 2 || g_order[0] != 1 || g_order[1] != 2) begin
      n_fail++; $display("FAIL two_grant_order: got %p expected 1,2", g_order); end
    n_checks++; if (g_ids.size() != 2 || g_ids[0] != 1 || g_ids[1] != 2) begin
      n_fail++; $display("FAIL two_rsp_ids: got %p expected 1,2", g_ids); end
    n_checks++; if (g_digs.size() != 2 || g_digs[0] !== DIG_ABC || g_digs[1] !== DIG_ABC) begin
      n_fail++; $display("FAIL two_digests: got %p expected abc twice", g_digs); end
    n_checks++; if (dut.w_rr_ptr !== PTR_AFTER_TWO) begin
      n_fail++; $display("FAIL two_rr_ptr: got %0d expected %0d", dut.w_rr_ptr, PTR_AFTER_TWO);
    end
  endtask

  task automatic test_lock();
    do_reset();
    clear_msgs();
    add_blk(0, BLK_448A, 1'b0);
    add_blk(0, BLK_448B, 1'b1);
    add_blk(3, BLK_ABC, 1'b1);
    m_start[3] = 1;
    run(2, 3, 300);
    n_checks++; if (bad_watch != 0) begin
      n_fail++; $display("FAIL lock_nonowner_ready: got %0d cycles expected 0", bad_watch); end
    n_checks++; if (multi_ready != 0) begin
      n_fail++; $display("FAIL lock_multi_ready: got %0d cycles expected 0", multi_ready); end
    n_checks++; if (g_ids.size() != 2 || g_ids[0] != 0 || g_ids[1] != 3) begin
      n_fail++; $display("FAIL lock_rsp_ids: got %p expected 0,3", g_ids); end
    n_checks++; if (g_digs.size() != 2 || g_digs[0] !== DIG_448) begin
      n_fail++; $display("FAIL lock_digest_448: got %h expected %h", g_digs[0], DIG_448); end
    n_checks++; if (g_digs.size() != 2 || g_digs[1] !== DIG_ABC) begin
      n_fail++; $display("FAIL lock_digest_req3: got %h expected %h", g_digs[1], DIG_ABC); end
  endtask

  task automatic test_hold();
    int bad_stab = 0;
    int bad_eor  = 0;
    int bad_gnt  = 0;
    req_data[512*1 +: 512] = BLK_ABC;
    req_last[1]  = 1'b1;
    req_valid[1] = 1'b1;
    rsp_ready    = 1'b0;
    #1;
    wait_hs(1, 50);
    wait_rsp(50);
    req_data[0 +: 512] = BLK_ABC;
    req_last[0]  = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== DIG_ABC || rsp_id !== 2'd1) bad_stab++;
      if (eng_data_out_ready !== 1'b0) bad_eor++;
      if (req_ready !== 4'h0) bad_gnt++;
      tick();
    end
    n_checks++; if (bad_stab != 0) begin
      n_fail++; $display("FAIL hold_rsp_stable: got %0d unstable cycles expected 0", bad_stab); end
    n_checks++; if (bad_eor != 0) begin
      n_fail++; $display("FAIL hold_eng_out_ready: got %0d cycles high expected 0", bad_eor); end
    n_checks++; if (bad_gnt != 0) begin
      n_fail++; $display("FAIL hold_no_grant: got %0d cycles with ready expected 0", bad_gnt); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_release_idle: got busy=%b rsp_valid=%b expected 0 0",
                         busy, rsp_valid); end
    tick();
    n_checks++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL hold_rearb: got busy=%b expected 1", busy); end
    wait_hs(0, 50);
    rsp_ready = 1'b1;
    wait_rsp(50);
    n_checks++; if (rsp_id !== 2'd0 || rsp_data !== DIG_ABC) begin
      n_fail++; $display("FAIL hold_next_rsp: got id=%0d data=%h expected id=0 data=%h",
                         rsp_id, rsp_data, DIG_ABC); end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    do_reset();
    req_data[0 +: 512] = BLK_448A;
    req_last[0]  = 1'b0;
    req_valid[0] = 1'b1;
    #1;
    wait_hs(0, 50);
    nrst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 256'h0 ||
                    rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b rsp_valid=%b id=%0d expected 0 0 0",
                         busy, rsp_valid, rsp_id); end
    n_checks++; if (req_ready !== 4'h0 || eng_data_in_valid !== 1'b0 ||
                    eng_data_out_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_handshakes: got ready=%h in_v=%b out_r=%b expected 0 0 0",
                         req_ready, eng_data_in_valid, eng_data_out_ready); end
    nrst = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (rsp_valid || busy) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin
      n_fail++; $display("FAIL midrst_no_rsp: got %0d active cycles expected 0", seen); end
    clear_msgs();
    add_blk(0, BLK_ABC, 1'b1);
    run(1, -1, 100);
    n_checks++; if (g_digs.size() != 1 || g_digs[0] !== DIG_ABC || g_ids[0] != 0) begin
      n_fail++; $display("FAIL midrst_fresh_abc: got %h expected %h", g_digs[0], DIG_ABC); end
  endtask

  task automatic test_prio();
    do_reset();
    clear_msgs();
    for (int k = 0; k < 3; k++) begin
      add_blk(0, BLK_ABC, 1'b1);
      add_blk(3, BLK_ABC, 1'b1);
    end
    run(6, -1, 600);
    n_checks++; if (g_order.size() != 6) begin
      n_fail++; $display("FAIL prio_grant_count: got %0d expected 6", g_order.size()); end
    for (int k = 0; k < 6 && k < g_order.size(); k++) begin
      n_checks++; if (g_order[k] != PRIO_ORDER[k] || g_ids[k] != PRIO_ORDER[k]) begin
        n_fail++; $display("FAIL prio_grant_%0d: got grant=%0d id=%0d expected %0d",
                           k, g_order[k], g_ids[k], PRIO_ORDER[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_req();
    test_lock();
    test_hold();
    test_reset_mid();
    test_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
